// File: rtl/seq_divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, with start/done handshake and error flags.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero,
    output logic                 overflow
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] q_acc;
    logic [WIDTH-1:0] dsr;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] next_rem;
    logic [WIDTH-1:0] next_q;

    // part_rem < dsr always holds, so trial < 2*dsr and the difference fits WIDTH bits
    always_comb begin
        trial    = {part_rem, shift[WIDTH-1]};
        q_bit    = (trial >= {1'b0, dsr});
        next_rem = q_bit ? WIDTH'(trial - {1'b0, dsr}) : trial[WIDTH-1:0];
        next_q   = {q_acc[WIDTH-2:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            part_rem    <= '0;
            shift       <= '0;
            q_acc       <= '0;
            dsr         <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                CALC: begin
                    part_rem <= next_rem;
                    q_acc    <= next_q;
                    shift    <= {shift[WIDTH-2:0], 1'b0};
                    cnt      <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        quotient  <= next_q;
                        remainder <= next_rem;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request
                    if (start) begin
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        quotient    <= '0;
                        remainder   <= '0;
                        dsr         <= divisor;
                        if (divisor == '0) begin
                            div_by_zero <= 1'b1;
                            quotient    <= '1;
                            remainder   <= '1;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
                            overflow    <= 1'b1;
                            quotient    <= '1;
                            remainder   <= '1;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            part_rem <= dividend[2*WIDTH-1:WIDTH];
                            shift    <= dividend[WIDTH-1:0];
                            q_acc    <= '0;
                            cnt      <= CW'(WIDTH);
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            state    <= CALC;
                        end
                    end else begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider (WIDTH=16) against
// hand-computed and constructed expected results.
module tb_seq_divider;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;
    int overlap = 0;

    seq_divider #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busy && done) overlap++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge, then wait (bounded) for done; lat counts edges incl. the start edge.
    task automatic run(input logic [31:0] dvd, input logic [15:0] dsr, output int lat);
        dividend = dvd;
        divisor  = dsr;
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_res(input string tag, input int lat, input int exp_lat,
                             input logic [15:0] q, input logic [15:0] r,
                             input logic dbz, input logic ovf);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_q"}, {16'b0, quotient}, {16'b0, q});
        chk({tag, "_r"}, {16'b0, remainder}, {16'b0, r});
        chk({tag, "_flags"}, {30'b0, div_by_zero, overflow}, {30'b0, dbz, ovf});
    endtask

    initial begin
        int lat;
        int dcount;
        logic [15:0] a, b, r;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        tick(); tick();
        chk("rst_outs", {busy, done, div_by_zero, overflow, quotient, remainder},
            {4'b0, 16'h0, 16'h0});
        rst = 1'b0;
        tick();

        run(32'h0626_0060, 16'h5678, lat);
        check_res("inverse", lat, 17, 16'h1234, 16'h0000, 1'b0, 1'b0);
        tick();
        chk("done_1cyc", {31'b0, done}, 32'd0);
        tick(); tick();
        chk("hold_q", {16'b0, quotient}, 32'h1234);

        run(32'h0000_1234, 16'h0000, lat);
        check_res("dbz", lat, 1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        chk("dbz_busy", {31'b0, busy}, 32'd0);

        run(32'h0001_0000, 16'h0001, lat);
        check_res("ovf", lat, 1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        chk("ovf_busy", {31'b0, busy}, 32'd0);
        tick();

        run(32'h0626_0061, 16'h5678, lat);
        check_res("rem1", lat, 17, 16'h1234, 16'h0001, 1'b0, 1'b0);
        run(32'hFFFE_0001, 16'hFFFF, lat);
        check_res("max", lat, 17, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        tick();

        // restart attempts with new operands during CALC must be ignored
        dividend = 32'h0626_0060; divisor = 16'h5678; start = 1'b1;
        tick();
        start = 1'b0; lat = 1;
        while (!done && lat < 40) begin
            if (lat == 3 || lat == 10) begin
                dividend = 32'h0000_0007; divisor = 16'h0003; start = 1'b1;
            end else begin
                dividend = 32'h0000_0000; divisor = 16'h0000; start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        check_res("ignore", lat, 17, 16'h1234, 16'h0000, 1'b0, 1'b0);
        tick();

        // start held across done: next division accepted in the DONE cycle
        dividend = 32'h0626_0061; divisor = 16'h5678; start = 1'b1;
        tick();
        dividend = 32'h0000_0064; divisor = 16'h0007; lat = 1;
        while (!done && lat < 40) begin tick(); lat++; end
        check_res("b2b_first", lat, 17, 16'h1234, 16'h0001, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        chk("b2b_accept", {30'b0, busy, done}, 32'd2);
        lat = 1;
        while (!done && lat < 40) begin tick(); lat++; end
        check_res("b2b_second", lat, 17, 16'd14, 16'd2, 1'b0, 1'b0);
        tick();

        // reset at iteration 8 aborts with no done pulse
        dividend = 32'h0626_0060; divisor = 16'h5678; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_outs", {busy, done, div_by_zero, overflow, quotient, remainder},
            {4'b0, 16'h0, 16'h0});
        dcount = 0;
        repeat (20) begin tick(); if (done) dcount++; end
        chk("midrst_nodone", dcount, 0);
        run(32'h0626_0061, 16'h5678, lat);
        check_res("after_rst", lat, 17, 16'h1234, 16'h0001, 1'b0, 1'b0);
        tick();

        for (int i = 0; i < 200; i++) begin
            a = 16'($urandom_range(1, 65535));
            b = 16'($urandom_range(1, 65535));
            r = 16'($urandom_range(0, b - 1));
            run(32'(a) * 32'(b) + 32'(r), b, lat);
            chk("rnd_lat", lat, 17);
            chk("rnd_q", {16'b0, quotient}, {16'b0, a});
            chk("rnd_r", {16'b0, remainder}, {16'b0, r});
            tick();
            chk("rnd_done_once", {31'b0, done}, 32'd0);
        end
        chk("busy_done_overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
# seq_divider

- Sequential restoring divider: 2·WIDTH-bit dividend ÷ WIDTH-bit divisor → WIDTH-bit quotient and remainder, one quotient bit per clock.
- Inverse of the combinational `multiplier`: the `multiplier` product with `b` as divisor returns `a` with zero remainder.
- Used wherever the datapath must undo a scaling. Operands are captured on a start/done handshake, so upstream logic can change them freely while a division runs.

## Interface
- WIDTH, 16, operand width; dividend is 2·WIDTH bits, quotient/remainder WIDTH bits
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request a division; sampled only when not busy
- dividend  input  2·WIDTH  numerator, captured on accepted start
- divisor  input  WIDTH  denominator, captured on accepted start
- busy  output  1  high while an iteration sequence is running
- done  output  1  one-cycle pulse, results valid
- quotient  output  WIDTH  result quotient, held until next accepted start
- remainder  output  WIDTH  result remainder, held until next accepted start
- div_by_zero  output  1  divisor was 0 for the last accepted start
- overflow  output  1  quotient would not fit in WIDTH bits (dividend[2W-1:W] ≥ divisor, divisor ≠ 0)

## Operation
- States: IDLE, CALC, DONE.
- IDLE/DONE + start=1: accept. Capture operands, clear both error flags, clear quotient/remainder registers.
  - divisor == 0: div_by_zero=1, quotient=all-ones, remainder=all-ones, → DONE.
  - else dividend[2W-1:W] ≥ divisor: overflow=1, quotient=all-ones, remainder=all-ones, → DONE.
  - else: partial remainder R ← dividend[2W-1:W], shift register ← dividend[W-1:0], counter ← WIDTH, → CALC.
- CALC, each cycle:
  - T = {R, next dividend bit (MSB first)}, WIDTH+1 bits.
  - T ≥ divisor: R ← T − divisor, quotient bit 1; else R ← T[W-1:0], quotient bit 0.
  - Quotient shifts in LSB-side; counter decrements.
  - After the WIDTH-th iteration: quotient and remainder outputs ← final values, → DONE.
- R < divisor is invariant, so T < 2·divisor and the subtraction result fits WIDTH bits. No other saturation or truncation.
- DONE: done=1 for exactly this one cycle. With no start → IDLE; with start → accepted as in IDLE.
- start while CALC: ignored; no queueing. Operand changes during CALC: no effect.
- Outputs quotient, remainder, div_by_zero and overflow hold their values through IDLE until the next accepted start.

## Timing
- Reset (rst=1 at an edge): state IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0. This applies mid-CALC too: the operation is aborted with no done pulse.
- Normal division: start sampled at edge E0 → busy=1 after E0. Iterations on edges E1..E_WIDTH. After E_WIDTH: busy=0, done=1 for one cycle. Latency is WIDTH+1 edges (17 for WIDTH=16).
- Error cases: start at E0 → done=1 and flag set right after E0 (1-edge latency). busy stays 0.
- busy and done are never high together.
- Back-to-back: start held high continuously gives one accepted division per WIDTH+1 cycles normal, one per cycle for errors.
- Results, flags and done all change on the same edge.

## Test plan
- Exact inverse: dividend=0x06260060, divisor=0x5678 → after 17 edges done=1, quotient=0x1234, remainder=0x0000, no flags.
- Remainder/extremes:
  - dividend=0x06260061, divisor=0x5678 → quotient=0x1234, remainder=0x0001.
  - dividend=0xFFFE0001, divisor=0xFFFF → quotient=0xFFFF, remainder=0x0000.
- Errors:
  - divisor=0 → done one cycle after start, div_by_zero=1, quotient=remainder=0xFFFF.
  - dividend=0x00010000, divisor=0x0001 → overflow=1, same outputs, busy never asserted.
- Handshake:
  - Start re-pulsed and operands changed at cycles 3 and 10 of a running division → ignored; original result returned at cycle 17.
  - start held high across done → next division accepted in the DONE cycle.
- Reset mid-operation: rst=1 at iteration 8 → all outputs 0 next cycle, no done pulse. A fresh start afterwards yields the correct result.
- Random self-check:
  - 200 pairs a, b in 1..65535: dividend=a·b+r with r<b → quotient=a, remainder=r, done exactly once per start, busy/done never overlap.
